// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// Optional feature macro: LOADER_CHECKSUM_EN adds the CSUM state.
package loader_pkg;

    localparam int HDR_W  = 16;   // width of the word-count header
    localparam int WORD_W = 32;   // instruction word width
    localparam int BYTE_W = 8;    // stream byte width

    // Loader states; CSUM exists only when the checksum trailer is enabled.
    typedef enum logic [2:0] {
        HDR_HI = 3'd0,
        HDR_LO = 3'd1,
        DATA   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        CSUM   = 3'd3,
`endif
        RUN    = 3'd4,
        ERR    = 3'd5
    } state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs payload bytes big-endian into 32-bit words; counts bytes modulo 4.
module word_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,       // asynchronous, active-low
    input  logic              clear,       // restart packing at a word boundary
    input  logic              byte_valid,  // accepted payload byte this cycle
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_done,   // this byte completes a word
    output logic [WORD_W-1:0] word         // completed word, valid with word_done
);

    localparam int SHIFT_W = WORD_W - BYTE_W;

    logic [1:0]         cnt_q, cnt_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;

    // Next-state for byte counter and the three earlier bytes of the word.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_valid) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[SHIFT_W-BYTE_W-1:0], byte_data};
        end
    end

    // Counter and shift register; idle cycles leave a partial word untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    // The fourth byte goes straight into the low lane, so the word is ready
    // on the same edge it is accepted.
    assign word_done = byte_valid && (cnt_q == 2'd3) && !clear;
    assign word      = {shift_q, byte_data};

endmodule

// File: rtl/prog_loader.sv
// Streams a program image (16-bit word count, then big-endian words) into
// instruction memory and holds the CPU in reset until the load completes.
// Optional feature macro: LOADER_CHECKSUM_EN (XOR checksum trailer byte).
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active-low
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);

    // Largest legal word count: the whole address space.
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t POST_PAYLOAD = CSUM;
`else
    localparam state_t POST_PAYLOAD = RUN;
`endif

    state_t              state_q, state_d;
    logic [HDR_W-1:0]    n_q;
    logic [ADDR_W-1:0]   wcnt_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [WORD_W-1:0]   mem_wdata_q;

    logic                ld_hi, ld_lo, issue_wr, new_load;
    logic                pay_byte, word_done, last_word;
    logic [HDR_W-1:0]    n_full;
    logic [WORD_W-1:0]   word;

    // Header count as it will be once the low byte currently offered lands.
    assign n_full    = {n_q[HDR_W-1:8], in_data};
    assign pay_byte  = (state_q == DATA) && in_valid;
    assign last_word = ({{(32-ADDR_W){1'b0}}, wcnt_q} + 32'd1) == {16'd0, n_q};

    word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (new_load),
        .byte_valid (pay_byte),
        .byte_data  (in_data),
        .word_done  (word_done),
        .word       (word)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q;

    // Running XOR over payload bytes, restarted with each new load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
        end else if (new_load) begin
            csum_q <= '0;
        end else if (pay_byte) begin
            csum_q <= csum_q ^ in_data;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HDR_HI;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, handshake and datapath strobes.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        ld_hi    = 1'b0;
        ld_lo    = 1'b0;
        issue_wr = 1'b0;
        new_load = 1'b0;
        unique case (state_q)
            HDR_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ld_hi   = 1'b1;
                    state_d = HDR_LO;
                end
            end
            HDR_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ld_lo = 1'b1;
                    if ({16'd0, n_full} > MAX_WORDS) begin
                        state_d = ERR;
                    end else if (n_full == '0) begin
                        state_d = POST_PAYLOAD;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (word_done) begin
                    issue_wr = 1'b1;
                    if (last_word) begin
                        state_d = POST_PAYLOAD;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = (in_data == csum_q) ? RUN : ERR;
                end
            end
`endif
            RUN, ERR: begin
                if (start) begin
                    new_load = 1'b1;
                    state_d  = HDR_HI;
                end
            end
            default: begin
                state_d = HDR_HI;
            end
        endcase
    end

    // Header count, word address and the registered memory write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_q         <= '0;
            wcnt_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= issue_wr;
            if (new_load) begin
                n_q    <= '0;
                wcnt_q <= '0;
            end
            if (ld_hi) begin
                n_q[HDR_W-1:8] <= in_data;
            end
            if (ld_lo) begin
                n_q[7:0] <= in_data;
            end
            if (issue_wr) begin
                mem_addr_q  <= wcnt_q;
                mem_wdata_q <= word;
                wcnt_q      <= wcnt_q + 1'b1;
            end
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_reset = (state_q != RUN);
    assign done      = (state_q == RUN);
    assign err       = (state_q == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected memory writes,
// a negedge monitor pops and compares each mem_we cycle.
module tb_prog_loader;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              err;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] seq[$];
    int         vec_cnt  = 0;
    int         miss_cnt = 0;

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset && mem_we) begin
            if (exp_q.size() == 0) begin
                vec_cnt++;
                miss_cnt++;
                $display("FAIL unexpected_write: got addr %0d data %h, required no write",
                         mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                $display("write addr %0d data %h (expected addr %0d data %h)",
                         mem_addr, mem_wdata, mon_e.addr, mon_e.data);
                chk("wr_addr", 32'(mem_addr), mon_e.addr);
                chk("wr_data", mem_wdata, mon_e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_seq();
        foreach (seq[i]) send_byte(seq[i]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_status(input string tag, input logic e_rdy, input logic e_cpu,
                              input logic e_done, input logic e_err);
        $display("status %s: in_ready=%b cpu_reset=%b done=%b err=%b", tag,
                 in_ready, cpu_reset, done, err);
        chk({tag, "_in_ready"},  32'(in_ready),  32'(e_rdy));
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(e_cpu));
        chk({tag, "_done"},      32'(done),      32'(e_done));
        chk({tag, "_err"},       32'(err),       32'(e_err));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values while reset is held low.
        #3;
        chk_status("reset", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("reset_mem_we",    32'(mem_we),   32'd0);
        chk("reset_mem_addr",  32'(mem_addr), 32'd0);
        chk("reset_mem_wdata", mem_wdata,     32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        idle(1);

        // N=2 load, two words.
        exp_q.push_back('{32'd0, 32'h20080005});
        exp_q.push_back('{32'd1, 32'h20090007});
        seq = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
`ifdef LOADER_CHECKSUM_EN
        seq.push_back(8'h03);
`endif
        send_seq();
        idle(1);
        chk_status("n2_run", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("n2_addr_hold",  32'(mem_addr), 32'd1);
        chk("n2_wdata_hold", mem_wdata,     32'h20090007);

        // N=0: straight to RUN, no writes.
        pulse_start();
        chk_status("restart", 1'b1, 1'b1, 1'b0, 1'b0);
        seq = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        seq.push_back(8'h00);
`endif
        send_seq();
        chk_status("n0_run", 1'b0, 1'b0, 1'b1, 1'b0);

        // N=1 with in_valid every other cycle, junk data on idle cycles and
        // a start pulse mid-load that must be ignored.
        pulse_start();
        exp_q.push_back('{32'd0, 32'hDEADBEEF});
        seq = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef LOADER_CHECKSUM_EN
        seq.push_back(8'h22);
`endif
        foreach (seq[i]) begin
            send_byte(seq[i]);
            if (i < seq.size() - 1) begin
                in_data = 8'h5A;
                start   = (i == 3);
                @(posedge clk); #1;
                start   = 1'b0;
            end
        end
        idle(1);
        chk_status("gappy_run", 1'b0, 1'b0, 1'b1, 1'b0);

        // N = 2^ADDR_W + 1 -> ERR; further bytes are refused.
        pulse_start();
        seq = '{8'h04, 8'h01};
        send_seq();
        chk_status("oversize", 1'b0, 1'b1, 1'b0, 1'b1);
        seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_seq();
        chk_status("err_hold", 1'b0, 1'b1, 1'b0, 1'b1);

        // Reset after two payload bytes, then a fresh N=1 load.
        pulse_start();
        seq = '{8'h00, 8'h01, 8'hAA, 8'hBB};
        send_seq();
        reset = 1'b0;
        #2;
        chk_status("midreset", 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.push_back('{32'd0, 32'h11223344});
        seq = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef LOADER_CHECKSUM_EN
        seq.push_back(8'h44);
`endif
        send_seq();
        idle(1);
        chk_status("fresh_run", 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum -> ERR, then start -> HDR_HI with CPU held.
        pulse_start();
        exp_q.push_back('{32'd0, 32'h11223344});
        seq = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        send_seq();
        chk_status("bad_csum", 1'b0, 1'b1, 1'b0, 1'b1);
        pulse_start();
        chk_status("err_restart", 1'b1, 1'b1, 1'b0, 1'b0);
`endif

        idle(4);
        chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
